// File: rtl/result_collector.sv
// result_collector: packs pipeline result pairs into PACK_NUM-lane words, queues them in a FWFT FIFO and streams them out
//   aclk/areset                   : clock, synchronous active-high reset
//   result_pair_input             : pipeline tail result, nonzero = valid pair
//   result_stage_feedback_output  : registered pause request to the pipeline
//   flush_req/flush_done          : end-of-batch flush request pulse / tlast-accepted pulse
//   m_tdata/m_tvalid/m_tready/m_tlast : packed word stream, lane 0 oldest in LSBs
//   result_count/overflow         : valid pair counter, sticky word-drop flag
`ifndef PARA_RESULT_PAIR_WIDTH
`define PARA_RESULT_PAIR_WIDTH 32
`endif
module result_collector #(
  parameter int RESULT_PAIR_WIDTH = `PARA_RESULT_PAIR_WIDTH,
  parameter int PACK_NUM = 8,
  parameter int WORD_DEPTH = 32,
  parameter int SLACK_WORDS = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic [RESULT_PAIR_WIDTH-1:0] result_pair_input,
  output logic result_stage_feedback_output,
  input  logic flush_req,
  output logic flush_done,
  output logic [PACK_NUM*RESULT_PAIR_WIDTH-1:0] m_tdata,
  output logic m_tvalid,
  input  logic m_tready,
  output logic m_tlast,
  output logic [31:0] result_count,
  output logic overflow
);
  localparam int W = RESULT_PAIR_WIDTH;
  localparam int DW = PACK_NUM * W;
  localparam int LW = $clog2(PACK_NUM);
  localparam int AW = $clog2(WORD_DEPTH);
  typedef enum logic [1:0] {IDLE, PEND, WAIT} state_t;
  state_t state, state_next;
  logic valid, last_lane, full, empty, pop, emit, push, push_ok;
  logic [LW-1:0] lane_cnt;
  logic [W-1:0] lanes [PACK_NUM-1];
  logic [DW-1:0] pack_word, flush_word;
  logic [DW:0] mem [WORD_DEPTH];
  logic [DW:0] push_data;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ, occ_next;
  assign valid = |result_pair_input;
  assign last_lane = lane_cnt == LW'(PACK_NUM - 1);
  assign full = occ == (AW+1)'(WORD_DEPTH);
  assign empty = occ == '0;
  assign pop = !empty && m_tready;
  // the flush word only goes out on a bubble so it never competes with a completing pair
  assign emit = state == PEND && !valid && !full;
  assign push = (valid && last_lane) || emit;
  assign push_ok = push && (!full || pop);
  assign push_data = emit ? {1'b1, flush_word} : {1'b0, pack_word};
  assign occ_next = occ + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign m_tvalid = !empty;
  assign {m_tlast, m_tdata} = empty ? '0 : mem[rd_ptr];
  assign flush_done = state == WAIT && m_tvalid && m_tready && m_tlast;
  assign state_next = (state == IDLE && flush_req) ? PEND :
                      emit ? WAIT :
                      flush_done ? IDLE : state;
  // unfilled lanes may hold stale pairs from the previous word, so mask them out
  always_comb begin
    pack_word = '0;
    flush_word = '0;
    for (int i = 0; i < PACK_NUM - 1; i++) begin
      pack_word[i*W +: W] = lanes[i];
      flush_word[i*W +: W] = (LW'(i) < lane_cnt) ? lanes[i] : '0;
    end
    pack_word[(PACK_NUM-1)*W +: W] = result_pair_input;
  end
  always_ff @(posedge aclk) begin
    if (valid && !last_lane) lanes[lane_cnt] <= result_pair_input;
    if (push_ok) mem[wr_ptr] <= push_data;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      lane_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      result_stage_feedback_output <= 1'b0;
      result_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      lane_cnt <= (emit || (valid && last_lane)) ? '0 : valid ? lane_cnt + 1'b1 : lane_cnt;
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop);
      occ <= occ_next;
      result_stage_feedback_output <= occ_next >= (AW+1)'(WORD_DEPTH - SLACK_WORDS);
      result_count <= result_count + 32'(valid);
      overflow <= overflow || (push && !push_ok);
    end
  end
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: table vectors, corner sequences and random traffic checked against a queue-level model
module tb_result_collector;
  localparam int PW = 16;
  localparam int DW = 8 * PW;
  typedef struct packed {logic last; logic [DW-1:0] data;} word_t;
  typedef struct {
    logic rst; logic [PW-1:0] p; logic f; logic r;
    logic ev; logic el; logic [DW-1:0] ed; logic [31:0] ec; logic edone;
  } vec_t;
  logic aclk = 0, areset = 0, flush_req = 0, m_tready = 0;
  logic [PW-1:0] pair = '0;
  logic result_stage_feedback_output, flush_done, m_tvalid, m_tlast, overflow;
  logic [DW-1:0] m_tdata;
  logic [31:0] result_count;
  int npass = 0, ntotal = 0;
  word_t q[$];
  logic [PW-1:0] pend[$];
  int phase = 0;
  logic [31:0] cnt = 0;
  logic ovf = 0, fb = 0, last_done = 0, done_seen = 0;
  vec_t tbl[$];
  result_collector #(.RESULT_PAIR_WIDTH(PW)) dut (
    .aclk(aclk), .areset(areset), .result_pair_input(pair),
    .result_stage_feedback_output(result_stage_feedback_output),
    .flush_req(flush_req), .flush_done(flush_done),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .result_count(result_count), .overflow(overflow)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic word_t mk(input logic l);
    word_t w;
    w.last = l;
    w.data = '0;
    for (int i = 0; i < pend.size(); i++) w.data[i*PW +: PW] = pend[i];
    pend.delete();
    return w;
  endfunction
  // phase: 0 idle, 1 flush requested, 2 flush word queued awaiting acceptance
  task automatic model_edge(input logic rst, input logic [PW-1:0] p, input logic f, input logic r);
    word_t w;
    logic have, popd, was_full;
    if (rst) begin
      q.delete(); pend.delete(); phase = 0; cnt = 0; ovf = 0; fb = 0;
      return;
    end
    have = 0;
    was_full = q.size() == 32;
    popd = q.size() != 0 && r;
    if (p != 0) begin
      cnt++;
      pend.push_back(p);
      if (pend.size() == 8) begin w = mk(1'b0); have = 1; end
    end else if (phase == 1 && !was_full) begin
      w = mk(1'b1); have = 1; phase = 2;
    end
    if (phase == 0 && f) phase = 1;
    if (popd) begin
      if (phase == 2 && q[0].last) phase = 0;
      void'(q.pop_front());
    end
    if (have) begin
      if (!was_full || popd) q.push_back(w);
      else ovf = 1;
    end
    fb = q.size() >= 28;
  endtask
  task automatic step(input logic rst, input logic [PW-1:0] p, input logic f, input logic r);
    logic exp_done;
    areset = rst; pair = p; flush_req = f; m_tready = r;
    #2;
    last_done = 0;
    if (!rst) begin
      exp_done = phase == 2 && q.size() != 0 && q[0].last && r;
      chk("flush_done", DW'(flush_done), DW'(exp_done));
      last_done = flush_done;
      if (flush_done === 1'b1) done_seen = 1;
    end
    @(posedge aclk);
    model_edge(rst, p, f, r);
    #1;
    chk("m_tvalid", DW'(m_tvalid), DW'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_tdata", m_tdata, q[0].data);
      chk("m_tlast", DW'(m_tlast), DW'(q[0].last));
    end else if (rst) begin
      chk("rst_tdata", m_tdata, '0);
      chk("rst_tlast", DW'(m_tlast), '0);
      chk("rst_flush_done", DW'(flush_done), '0);
    end
    chk("result_count", DW'(result_count), DW'(cnt));
    chk("overflow", DW'(overflow), DW'(ovf));
    chk("feedback", DW'(result_stage_feedback_output), DW'(fb));
  endtask
  task automatic add(input logic rst, input logic [PW-1:0] p, input logic f, input logic ev,
                     input logic el, input logic [DW-1:0] ed, input logic [31:0] ec, input logic edone);
    tbl.push_back('{rst, p, f, 1'b1, ev, el, ed, ec, edone});
  endtask
  function automatic logic [PW-1:0] nz();
    return PW'($urandom_range(1, 65535));
  endfunction
  initial begin
    add(1, 0, 0, 0, 0, '0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, PW'(i), 0, i == 8, 0, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 32'(i), 0);
    add(0, 0, 0, 0, 0, '0, 8, 0);
    add(1, 0, 0, 0, 0, '0, 0, 0);
    add(0, 5, 0, 0, 0, '0, 1, 0);
    add(0, 0, 0, 0, 0, '0, 1, 0);
    add(0, 0, 0, 0, 0, '0, 1, 0);
    add(0, 6, 0, 0, 0, '0, 2, 0);
    add(0, 7, 0, 0, 0, '0, 3, 0);
    add(0, 0, 0, 0, 0, '0, 3, 0);
    for (int i = 8; i <= 12; i++)
      add(0, PW'(i), 0, i == 12, 0, 128'h000c_000b_000a_0009_0008_0007_0006_0005, 32'(i - 4), 0);
    add(0, 13, 0, 0, 0, '0, 9, 0);
    add(0, 0, 1, 0, 0, '0, 9, 0);
    add(0, 0, 0, 1, 1, 128'h000d, 9, 0);
    add(0, 0, 0, 0, 0, '0, 9, 1);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].p, tbl[i].f, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), DW'(m_tvalid), DW'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), m_tdata, tbl[i].ed);
        chk($sformatf("tbl%0d_last", i), DW'(m_tlast), DW'(tbl[i].el));
      end
      chk($sformatf("tbl%0d_count", i), DW'(result_count), DW'(tbl[i].ec));
      chk($sformatf("tbl%0d_done", i), DW'(last_done), DW'(tbl[i].edone));
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, nz(), 0, 1);
    step(0, 0, 1, 1);
    done_seen = 0;
    for (int k = 0; k < 20 && !done_seen; k++) step(0, 0, 0, 1);
    chk("flush_partial_done", DW'(done_seen), 1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    done_seen = 0;
    for (int k = 0; k < 20 && !done_seen; k++) step(0, 0, 0, 1);
    chk("flush_empty_done", DW'(done_seen), 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, nz(), 0, 1);
    step(0, nz(), 1, 1);
    chk("collide_word_last", DW'(m_tlast), 0);
    done_seen = 0;
    for (int k = 0; k < 20 && !done_seen; k++) step(0, 0, 0, 1);
    chk("collide_done", DW'(done_seen), 1);
    step(1, 0, 0, 0);
    for (int w = 1; w <= 33; w++) begin
      for (int k = 0; k < 8; k++) step(0, PW'(w * 8 + k), 0, 0);
      if (w == 27) chk("fb_at_27", DW'(result_stage_feedback_output), 0);
      if (w == 28) chk("fb_at_28", DW'(result_stage_feedback_output), 1);
      if (w == 32) chk("ovf_at_32", DW'(overflow), 0);
      if (w == 33) chk("ovf_at_33", DW'(overflow), 1);
    end
    for (int k = 0; k < 40; k++) step(0, 0, 0, 1);
    chk("drain_fb", DW'(result_stage_feedback_output), 0);
    chk("drain_empty", DW'(m_tvalid), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 28; i++) step(0, nz(), 0, 0);
    step(0, nz(), 1, 0);
    step(1, 0, 0, 0);
    chk("rst_mid_valid", DW'(m_tvalid), 0);
    chk("rst_mid_count", DW'(result_count), 0);
    for (int i = 0; i < 7; i++) step(0, nz(), 0, 1);
    step(0, 0, 0, 1);
    chk("rst_mid_no_word", DW'(m_tvalid), 0);
    step(0, nz(), 0, 1);
    chk("rst_mid_new_word", DW'(m_tvalid), 1);
    for (int k = 0; k < 3000; k++) begin
      logic [PW-1:0] p;
      p = ($urandom_range(0, 2) != 0) ? nz() : '0;
      step(0, p, $urandom_range(0, 39) == 0, (k % 600) < 400 ? $urandom_range(0, 9) < 7 : $urandom_range(0, 9) < 2);
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Terminal consumer for the join pipeline's result output. Samples the one-cycle result pairs from the last pipeline stage and packs them into `PACK_NUM`-lane words. Buffers the words in a first-word-fall-through FIFO and presents them to the memory writer over a valid/ready stream. Drives the pipeline's result feedback (pause) input so that in-flight results are never lost, and handles the end-of-batch flush.

## Interface
Parameters:
- `RESULT_PAIR_WIDTH`, default `` `PARA_RESULT_PAIR_WIDTH ``: width of one result pair.
- `PACK_NUM`, default 8: pairs per output word; power of two, ≥2.
- `WORD_DEPTH`, default 32: output FIFO depth in words; power of two.
- `SLACK_WORDS`, default 4: free words reserved for results still in flight after feedback asserts.

Ports:
- `aclk` in 1: clock. All logic runs on its rising edge.
- `areset` in 1: reset, synchronous, active-high.
- `result_pair_input` in `RESULT_PAIR_WIDTH`: tail result of the pipeline. A nonzero value is a valid pair. An all-zero value is "no result".
- `result_stage_feedback_output` out 1: registered pause signal to the pipeline's result feedback input. High requests a pause.
- `flush_req` in 1: single-cycle pulse at end of batch.
- `flush_done` out 1: single-cycle pulse when the final (tlast) word is accepted downstream.
- `m_tdata` out `PACK_NUM*RESULT_PAIR_WIDTH`: packed word. Lane 0 is in the LSBs and holds the oldest pair.
- `m_tvalid` out 1: word available.
- `m_tready` in 1: downstream accepts.
- `m_tlast` out 1: marks the flush word.
- `result_count` out 32: total valid pairs accepted since reset. Wraps modulo 2^32.
- `overflow` out 1: sticky error flag.

## Operation
- Packer state:
  - `lane_cnt` ranges 0..PACK_NUM-1.
  - `lanes[PACK_NUM-2:0]` are the pair registers.
- Valid pair, `lane_cnt` < PACK_NUM-1: store the pair in `lanes[lane_cnt]`, then `lane_cnt`++.
- Valid pair, `lane_cnt` = PACK_NUM-1: push word {pair, lanes} into the FIFO with tlast=0, then `lane_cnt`=0.
- Valid pairs are always accepted, including while feedback is high, because they were already in flight.
- `result_count` increments by 1 per valid pair.
- Flush FSM:
  - IDLE → PEND on `flush_req`.
  - PEND → EMIT on the first cycle with no valid pair and FIFO not full.
  - EMIT pushes the current lanes with unfilled lanes zero and tlast=1. When `lane_cnt`=0, it pushes an all-zero word with tlast=1. It then clears `lane_cnt` and goes to WAIT.
  - WAIT → IDLE when the tlast word is handshaken (`m_tvalid`&`m_tready`&`m_tlast`). `flush_done` pulses in that same cycle.
  - `flush_req` outside IDLE is ignored.
  - Valid pairs arriving in PEND are packed normally before the flush word.
- Feedback: `result_stage_feedback_output` <= (next FIFO occupancy ≥ WORD_DEPTH−SLACK_WORDS).
- Overflow: a push while the FIFO is full and not popping in the same cycle drops that word and sets `overflow`. `overflow` is cleared only by reset.
- A push and a pop in the same cycle leave occupancy unchanged. A push to a full FIFO with a simultaneous pop succeeds.

## Timing
- Reset values: `result_stage_feedback_output`=0, `flush_done`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `result_count`=0, `overflow`=0. FIFO is empty, `lane_cnt`=0, flush FSM is in IDLE.
- Reset mid-operation discards partial lanes, FIFO contents and any pending flush. Reset takes priority over every input in that cycle.
- Input sampling: `result_pair_input` is sampled every edge and needs no handshake. Each pair is present for exactly one cycle.
- Latency: the completing pair sampled at edge E gives `m_tvalid`=1 in the cycle after E when the FIFO was empty. The same latency applies to the flush word relative to the EMIT edge.
- `m_tdata`, `m_tvalid` and `m_tlast` are held stable while `m_tvalid`=1 and `m_tready`=0.
- Feedback is registered: it rises one cycle after the occupancy crosses the threshold. It deasserts one cycle after occupancy drops below WORD_DEPTH−SLACK_WORDS.

## Test plan
- **Basic pack:** 8 consecutive pairs 1..8, `m_tready`=1. Required response:
  - One word with lanes 1..8 in order, tlast=0, `m_tvalid` one cycle after pair 8.
  - `result_count`=8.
- **Gaps and zeros:** pairs 5, 0, 0, 6, 7, 0, 8, 9, 10, 11, 12, 13. Required response:
  - One word containing 5..12.
  - `lane_cnt`=1 holding 13.
  - `result_count`=9.
- **Flush partial:** after 3 pairs A, B, C, pulse `flush_req`. Required response:
  - Word {0,0,0,0,0,C,B,A} with tlast=1.
  - `flush_done` pulses on its handshake.
- **Flush empty / collision:**
  - `flush_req` with `lane_cnt`=0 → all-zero word with tlast=1.
  - `flush_req` in the same cycle as the 8th pair → full word with tlast=0, then all-zero word with tlast=1.
- **Backpressure:** `m_tready`=0 and a continuous pair stream. Required response:
  - Feedback rises the cycle after occupancy reaches 28 (defaults).
  - 4 more words are accepted without loss.
  - The 33rd word sets `overflow`=1.
  - Releasing `m_tready` drains words in order and drops feedback once occupancy falls below 28.
- **Reset mid-batch:** `areset` during PEND with 5 lanes filled and 3 words queued. Required response:
  - All outputs return to reset values on the next cycle.
  - No word is emitted afterwards until 8 new pairs arrive.
